// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V pipeline constants
package riscv_pkg;
    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with kill-over-hold priority
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] BUBBLE = NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_hold,
    input  logic            i_kill,
    input  logic [ILEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic [ILEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);
    // reset, then kill inserts a bubble, then hold freezes, else capture the fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            o_inst     <= BUBBLE;
            o_pc       <= '0;
            o_pc_plus4 <= XLEN'(4);
            o_valid    <= 1'b0;
        end else if (i_kill) begin
            o_inst     <= BUBBLE;
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc + XLEN'(4);
            o_valid    <= 1'b0;
        end else if (!i_hold) begin
            o_inst     <= i_inst;
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc + XLEN'(4);
            o_valid    <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC mux and IF/ID register for instruction fetch
module fetch_stage #(
    parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP      = riscv_pkg::NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_f,
    input  logic              flush_d,
    input  logic              redirect_e,
    input  logic [31:0]       target_e,
    input  logic [31:0]       inst_f,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       pc_f,
    output logic [31:0]       pc_d,
    output logic [31:0]       pc_plus4_d,
    output logic [31:0]       inst_d,
    output logic              valid_d,
    output logic              misalign_e
);
    logic [31:0] r_pc;
    logic        r_misalign;
    logic [31:0] w_pc_next;
    // redirect beats stall; redirect targets are forced to word alignment
    always_comb begin
        w_pc_next = redirect_e ? {target_e[31:2], 2'b00} : stall_f ? r_pc : r_pc + 32'd4;
    end
    // PC register and one-cycle misaligned-target flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_misalign <= redirect_e && (target_e[1:0] != 2'b00);
        end
    end
    if_id_reg #(.BUBBLE(NOP)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_hold     (stall_f),
        .i_kill     (redirect_e | flush_d),
        .i_inst     (inst_f),
        .i_pc       (r_pc),
        .o_inst     (inst_d),
        .o_pc       (pc_d),
        .o_pc_plus4 (pc_plus4_d),
        .o_valid    (valid_d)
    );
    assign pc_f       = r_pc;
    assign address    = r_pc[ADDR_W-1:0];
    assign misalign_e = r_misalign;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed check of fetch_stage against a behavioural model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall_f, flush_d, redirect_e;
    logic [31:0] target_e, inst_f;
    logic [9:0]  address;
    logic [31:0] pc_f, pc_d, pc_plus4_d, inst_d;
    logic        valid_d, misalign_e;
    logic [31:0] mem [256];
    logic [31:0] m_pc, m_pc_d, m_p4, m_inst;
    logic        m_valid, m_mis;
    int          total = 0;
    int          bad = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
        .redirect_e(redirect_e), .target_e(target_e), .inst_f(inst_f),
        .address(address), .pc_f(pc_f), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .inst_d(inst_d), .valid_d(valid_d), .misalign_e(misalign_e)
    );

    always #5 clk = ~clk;
    always_comb inst_f = mem[address[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic d, input logic [31:0] t);
        logic [31:0] fetched;
        @(negedge clk);
        rst = r; stall_f = s; flush_d = f; redirect_e = d; target_e = t;
        @(posedge clk);
        fetched = mem[m_pc[9:2]];
        if (r) begin
            m_pc = 32'h0; m_inst = 32'h13; m_pc_d = 32'h0; m_p4 = 32'h4; m_valid = 0; m_mis = 0;
        end else begin
            m_mis = d && (t % 4 != 0);
            if (d || f) begin
                m_inst = 32'h13; m_valid = 0; m_pc_d = m_pc; m_p4 = m_pc + 4;
            end else if (!s) begin
                m_inst = fetched; m_valid = 1; m_pc_d = m_pc; m_p4 = m_pc + 4;
            end
            m_pc = d ? t - (t % 4) : s ? m_pc : m_pc + 4;
        end
        #1;
        chk("pc_f", pc_f, m_pc);
        chk("address", {22'd0, address}, {22'd0, m_pc[9:0]});
        chk("pc_d", pc_d, m_pc_d);
        chk("pc_plus4_d", pc_plus4_d, m_p4);
        chk("inst_d", inst_d, m_inst);
        chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        chk("misalign_e", {31'd0, misalign_e}, {31'd0, m_mis});
    endtask

    task automatic run_to(input logic [31:0] pc);
        for (int i = 0; i < 300 && m_pc != pc; i++) step(0, 0, 0, 0, 0);
        chk("run_to_pc", pc_f, pc);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1; stall_f = 0; flush_d = 0; redirect_e = 0; target_e = 0;
        m_pc = 0; m_inst = 0; m_pc_d = 0; m_p4 = 0; m_valid = 0; m_mis = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("first_inst", inst_d, mem[0]);
        run_to(32'h10);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("stall_hold_pc_d", pc_d, 32'h0C);
        step(0, 0, 0, 0, 0);
        chk("stall_resume", pc_d, 32'h10);
        run_to(32'h20);
        step(0, 0, 0, 1, 32'h40);
        chk("redir_bubble", {31'd0, valid_d}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("redir_target_inst", inst_d, mem[32'h40 >> 2]);
        step(0, 0, 0, 1, 32'h42);
        chk("misalign_pulse", {31'd0, misalign_e}, 32'd1);
        step(0, 0, 0, 0, 0);
        chk("misalign_clear", {31'd0, misalign_e}, 32'd0);
        step(0, 1, 1, 1, 32'h123);
        step(0, 0, 0, 1, 32'h80);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h3F0);
        run_to(32'h400);
        step(0, 0, 0, 0, 0);
        chk("wrap_inst", inst_d, mem[0]);
        step(1, 0, 0, 1, 32'h55);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FF));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
